// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: LSB-first A - B - BIN through one full-subtractor
// cell, one bit per clock, with a busy/done handshake.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FINISH
  } state_t;

  state_t state;
  state_t nxt;

  logic             load;
  logic             step;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] d_sr;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             last;
  logic             d_bit;
  logic             br_nxt;

  assign last = (cnt == CW'(WIDTH - 1));

  // full-subtractor cell on the current LSBs
  assign d_bit  = a_sr[0] ^ b_sr[0] ^ br;
  assign br_nxt = (~a_sr[0] & b_sr[0]) |
                  (~(a_sr[0] ^ b_sr[0]) & br);

  assign diff = d_sr;
  assign bout = br;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // next state, datapath controls and handshake outputs
  always_comb begin
    nxt  = state;
    load = 1'b0;
    step = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          load = 1'b1;
          nxt  = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) begin
          nxt = FINISH;
        end
      end
      FINISH: begin
        done = 1'b1;
        if (start) begin
          load = 1'b1;
          nxt  = SHIFT;
        end else begin
          nxt = IDLE;
        end
      end
      default: begin
        nxt = IDLE;
      end
    endcase
  end

  // operand capture and one-bit-per-cycle shifting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr <= '0;
      b_sr <= '0;
      d_sr <= '0;
      br   <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      a_sr <= a;
      b_sr <= b;
      br   <= bin;
      cnt  <= '0;
    end else if (step) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      d_sr <= {d_bit, d_sr[WIDTH-1:1]};
      br   <= br_nxt;
      cnt  <= cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed-vector and random bench for serial_subtractor at
// widths 8 and 16.
module tb_serial_subtractor;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        bin;
  logic        busy;
  logic        done;
  logic [7:0]  diff;
  logic        bout;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        bin16;
  logic        busy16;
  logic        done16;
  logic [15:0] diff16;
  logic        bout16;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start),
    .a(a), .b(b), .bin(bin),
    .busy(busy), .done(done),
    .diff(diff), .bout(bout)
  );

  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst), .start(start16),
    .a(a16), .b(b16), .bin(bin16),
    .busy(busy16), .done(done16),
    .diff(diff16), .bout(bout16)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [7:0] x;
    logic [7:0] y;
    logic       ci;
    logic [7:0] d;
    logic       bo;
    string      nm;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, exp);
    end
  endtask

  // caller sits 1 time unit after a rising edge
  task automatic issue8(input logic [7:0] x,
                        input logic [7:0] y,
                        input logic ci);
    start = 1'b1;
    a = x;
    b = y;
    bin = ci;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    bin = 1'($urandom);
  endtask

  // counts edges until DONE is seen; flags busy gaps and overlap
  task automatic wait8(output int lat, output int bad);
    lat = 0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (busy && done) bad = 1;
      if (done) break;
      if (!busy) bad = 1;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] x,
                      input logic [7:0] y,
                      input logic ci,
                      input logic [8:0] exp,
                      input string nm);
    int lat;
    int bad;
    issue8(x, y, ci);
    wait8(lat, bad);
    chk({nm, "_lat"}, 32'(lat), 32'd8);
    chk({nm, "_res"}, {23'd0, bout, diff}, {23'd0, exp});
    chk({nm, "_bsy"}, 32'(bad), 32'd0);
  endtask

  task automatic run16(input logic [15:0] x,
                       input logic [15:0] y,
                       input logic ci);
    int lat;
    int bad;
    logic [16:0] exp;
    exp = 17'(x) - 17'(y) - 17'(ci);
    start16 = 1'b1;
    a16 = x;
    b16 = y;
    bin16 = ci;
    @(posedge clk);
    #1;
    start16 = 1'b0;
    a16 = 16'($urandom);
    b16 = 16'($urandom);
    bin16 = 1'($urandom);
    lat = 0;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy16 && done16) bad = 1;
      if (done16) break;
      if (!busy16) bad = 1;
      @(posedge clk);
      #1;
      lat++;
    end
    chk("r16_lat", 32'(lat), 32'd16);
    chk("r16_res", {15'd0, bout16, diff16}, {15'd0, exp});
    chk("r16_bsy", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int bad;
    logic sawd;
    logic [7:0] x;
    logic [7:0] y;
    logic ci;
    logic [8:0] e;

    tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, "v05m03"};
    tbl[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, "v03m05"};
    tbl[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, "v00b1"};
    tbl[3] = '{8'h80, 8'h7F, 1'b0, 8'h01, 1'b0, "v80m7f"};
    tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "vffffb"};
    tbl[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0, "vffm00"};
    tbl[6] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, "v00mff"};
    tbl[7] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, "v10m01"};
    tbl[8] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, "vzero"};
    tbl[9] = '{8'h55, 8'hAA, 1'b1, 8'hAA, 1'b1, "v55aab"};

    rst = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    start16 = 1'b0;
    a16 = '0;
    b16 = '0;
    bin16 = 1'b0;

    // reset takes effect before any clock edge
    #1 rst = 1'b1;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out", {23'd0, bout, diff}, 32'd0);
    chk("rst_out16", {15'd0, bout16, diff16}, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    // first START right after reset release
    for (int i = 0; i < 10; i++) begin
      run8(tbl[i].x, tbl[i].y, tbl[i].ci,
           {tbl[i].bo, tbl[i].d}, tbl[i].nm);
      @(posedge clk);
      #1;
      chk("idle_busy", {30'd0, busy, done}, 32'd0);
    end

    // result held while idle with inputs wiggling
    repeat (3) begin
      a = 8'($urandom);
      b = 8'($urandom);
      bin = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("hold", {23'd0, bout, diff}, {23'd0, 1'b1, 8'hAA});

    // START held during SHIFT must be ignored
    start = 1'b1;
    a = 8'hA0;
    b = 8'h20;
    bin = 1'b0;
    @(posedge clk);
    #1;
    a = 8'hFF;
    b = 8'h00;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    wait8(lat, bad);
    chk("ign_lat", 32'(lat), 32'd4);
    chk("ign_res", {23'd0, bout, diff}, {23'd0, 9'h080});
    @(posedge clk);
    #1;

    // back-to-back through FINISH
    issue8(8'h05, 8'h03, 1'b0);
    wait8(lat, bad);
    chk("b2b_first", {23'd0, bout, diff}, {23'd0, 9'h002});
    start = 1'b1;
    a = 8'h10;
    b = 8'h01;
    bin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b_busy", {31'd0, busy}, 32'd1);
    wait8(lat, bad);
    chk("b2b_lat", 32'(lat), 32'd8);
    chk("b2b_res", {23'd0, bout, diff}, {23'd0, 9'h00F});
    chk("b2b_bsy", 32'(bad), 32'd0);
    @(posedge clk);
    #1;

    // asynchronous abort in the 4th SHIFT cycle
    issue8(8'h12, 8'h34, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_ctl", {30'd0, busy, done}, 32'd0);
    chk("abort_out", {23'd0, bout, diff}, 32'd0);
    #1 rst = 1'b0;
    sawd = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) sawd = 1'b1;
    end
    chk("abort_nodone", {31'd0, sawd}, 32'd0);
    run8(8'h80, 8'h7F, 1'b0, 9'h001, "post_abort");
    @(posedge clk);
    #1;

    // random vectors against unsigned reference
    for (int i = 0; i < 600; i++) begin
      x = 8'($urandom);
      y = 8'($urandom);
      ci = 1'($urandom);
      e = 9'(x) - 9'(y) - 9'(ci);
      run8(x, y, ci, e, "rnd8");
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < 600; i++) begin
      run16(16'($urandom), 16'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
